// File: rtl/ioctl_loader_pkg.sv
// Shared definitions for the ioctl download loader: field widths, the
// ioctl address width of the glue layer, and the write-engine state encoding.
package ioctl_loader_pkg;

    localparam int IOCTL_AW     = 25;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_AW       = 19;
    localparam int DEF_DW       = 8;

    function automatic int chw_of(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    localparam int DEF_CHW     = chw_of(DEF_CHANNELS);
    localparam int DEF_ENTRY_W = DEF_CHW + DEF_AW + DEF_DW;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty are derived
// from the registered count so they never depend on same-cycle pops.
module loader_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d   = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ioctl_loader.sv
// Routes the data_io download stream by index to one of CHANNELS memory targets,
// buffers the bytes and writes them to slow memory over a req/ack handshake.
module ioctl_loader
    import ioctl_loader_pkg::*;
#(
    parameter int  CHANNELS   = DEF_CHANNELS,
    parameter int  BASE_INDEX = 0,
    parameter int  IDXW       = 8,
    parameter int  AW         = DEF_AW,
    parameter int  DW         = DEF_DW,
    parameter int  DEPTH      = 8,
    localparam int CHW        = chw_of(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dlActive,
    input  logic [IDXW-1:0]     dlIndex,
    input  logic                dlWr,
    input  logic [IOCTL_AW-1:0] dlA,
    input  logic [DW-1:0]       dlD,
    output logic                dlWait,
    output logic                memReq,
    output logic [CHW-1:0]      memCh,
    output logic [AW-1:0]       memA,
    output logic [DW-1:0]       memD,
    input  logic                memAck,
    output logic                init,
    output logic [CHANNELS-1:0] loaded,
    output logic [AW:0]         lastSize,
    output logic                overflow,
    output logic                rangeErr
);
    localparam int          EW      = CHW + AW + DW;
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic dl_active_q, dl_active_d, init_q, init_d;
    logic overflow_q, overflow_d, range_err_q, range_err_d;
    logic in_range_q, in_range_d, dl_wait_q, dl_wait_d, mem_req_q, mem_req_d;
    logic [CHW-1:0]      cur_ch_q, cur_ch_d, mem_ch_q, mem_ch_d;
    logic [AW-1:0]       mem_a_q, mem_a_d;
    logic [DW-1:0]       mem_d_q, mem_d_d;
    logic [AW:0]         cnt_q, cnt_d, last_size_q, last_size_d, cnt_base_s;
    logic [CHANNELS-1:0] loaded_q, loaded_d;
    wr_state_e           state_q, state_d;
    logic [IDXW-1:0]     diff_s;
    logic                start_s, wr_s, addr_ok_s, accept_s, push_s, pop_s, done_s;
    logic [EW-1:0]       fifo_din_s, fifo_dout_s;
    logic                fifo_full_s, fifo_empty_s;
    logic [CW-1:0]       fifo_count_s;

    loader_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Download start/end tracking, byte acceptance and sticky status flags
    always_comb begin
        diff_s      = dlIndex - IDXW'(BASE_INDEX);
        start_s     = dlActive & ~dl_active_q;
        dl_active_d = dlActive;
        init_d      = init_q;
        overflow_d  = overflow_q;
        range_err_d = range_err_q;
        last_size_d = last_size_q;
        loaded_d    = loaded_q;
        dl_wait_d   = (fifo_count_s >= CW'(DEPTH - 2));
        if (start_s) begin
            init_d      = 1'b0;
            overflow_d  = 1'b0;
            range_err_d = 1'b0;
            cur_ch_d    = diff_s[CHW-1:0];
            in_range_d  = (diff_s < IDXW'(CHANNELS));
            cnt_base_s  = {(AW+1){1'b0}};
        end else begin
            cur_ch_d    = cur_ch_q;
            in_range_d  = in_range_q;
            cnt_base_s  = cnt_q;
        end
        // A strobe in the start cycle already uses the freshly decoded channel
        wr_s       = dlWr & dlActive;
        addr_ok_s  = ((dlA >> AW) == {IOCTL_AW{1'b0}});
        accept_s   = wr_s & in_range_d & addr_ok_s;
        push_s     = accept_s & ~fifo_full_s;
        fifo_din_s = {cur_ch_d, dlA[AW-1:0], dlD};
        if (push_s && (cnt_base_s != CNT_MAX)) begin
            cnt_d = cnt_base_s + CNT_ONE;
        end else begin
            cnt_d = cnt_base_s;
        end
        if (wr_s && !accept_s) begin
            range_err_d = 1'b1;
        end else if (accept_s && fifo_full_s) begin
            overflow_d = 1'b1;
        end else begin
            range_err_d = range_err_d;
        end
        done_s = ~dlActive & fifo_empty_s & (state_q == ST_IDLE) & ~start_s & ~init_q;
        if (done_s) begin
            init_d      = 1'b1;
            last_size_d = cnt_q;
            for (int i = 0; i < CHANNELS; i++) begin
                if ((cur_ch_q == CHW'(i)) && in_range_q && (cnt_q != {(AW+1){1'b0}})) begin
                    loaded_d[i] = 1'b1;
                end else begin
                    loaded_d[i] = loaded_q[i];
                end
            end
        end else begin
            loaded_d = loaded_q;
        end
    end

    // Write engine: pop the FIFO head into the output registers, hold until ack
    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        mem_ch_d  = mem_ch_q;
        mem_a_d   = mem_a_q;
        mem_d_d   = mem_d_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s                       = 1'b1;
                    {mem_ch_d, mem_a_d, mem_d_d} = fifo_dout_s;
                    mem_req_d                   = 1'b1;
                    state_d                     = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State registers; the edge detector clears on reset so a held dlActive restarts
    always_ff @(posedge clock) begin
        if (reset) begin
            dl_active_q <= 1'b0;
            init_q      <= 1'b1;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
            in_range_q  <= 1'b0;
            dl_wait_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            cur_ch_q    <= {CHW{1'b0}};
            mem_ch_q    <= {CHW{1'b0}};
            mem_a_q     <= {AW{1'b0}};
            mem_d_q     <= {DW{1'b0}};
            cnt_q       <= {(AW+1){1'b0}};
            last_size_q <= {(AW+1){1'b0}};
            loaded_q    <= {CHANNELS{1'b0}};
            state_q     <= ST_IDLE;
        end else begin
            dl_active_q <= dl_active_d;
            init_q      <= init_d;
            overflow_q  <= overflow_d;
            range_err_q <= range_err_d;
            in_range_q  <= in_range_d;
            dl_wait_q   <= dl_wait_d;
            mem_req_q   <= mem_req_d;
            cur_ch_q    <= cur_ch_d;
            mem_ch_q    <= mem_ch_d;
            mem_a_q     <= mem_a_d;
            mem_d_q     <= mem_d_d;
            cnt_q       <= cnt_d;
            last_size_q <= last_size_d;
            loaded_q    <= loaded_d;
            state_q     <= state_d;
        end
    end

    assign dlWait   = dl_wait_q;
    assign memReq   = mem_req_q;
    assign memCh    = mem_ch_q;
    assign memA     = mem_a_q;
    assign memD     = mem_d_q;
    assign init     = init_q;
    assign loaded   = loaded_q;
    assign lastSize = last_size_q;
    assign overflow = overflow_q;
    assign rangeErr = range_err_q;

endmodule

// File: tb/tb_ioctl_loader.sv
// Scoreboard bench for ioctl_loader: expected writes are queued as bytes are
// strobed and compared against the writes captured from the memory port.
module tb_ioctl_loader;
    localparam int EW = 2 + 19 + 8;

    logic        clock = 1'b0;
    logic        reset, dlActive, dlWr, memAck;
    logic [7:0]  dlIndex;
    logic [24:0] dlA;
    logic [7:0]  dlD;
    logic        dlWait, memReq, init, overflow, rangeErr;
    logic [1:0]  memCh;
    logic [18:0] memA;
    logic [7:0]  memD;
    logic [3:0]  loaded;
    logic [19:0] lastSize;

    int tests = 0;
    int fails = 0;
    bit ack_en;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    ioctl_loader #(.CHANNELS(4), .BASE_INDEX(0), .IDXW(8), .AW(19), .DW(8), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .dlActive(dlActive), .dlIndex(dlIndex), .dlWr(dlWr),
        .dlA(dlA), .dlD(dlD), .dlWait(dlWait), .memReq(memReq), .memCh(memCh), .memA(memA),
        .memD(memD), .memAck(memAck), .init(init), .loaded(loaded), .lastSize(lastSize),
        .overflow(overflow), .rangeErr(rangeErr)
    );

    always #5 clock = ~clock;

    // Advance one cycle, acting as the memory: ack each request one cycle later
    task automatic tick();
        if (memAck) begin
            memAck = 1'b0;
        end else if (ack_en && memReq) begin
            obs_q.push_back({memCh, memA, memD});
            memAck = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic strobe(input logic [1:0] ch, input logic [24:0] a, input logic [7:0] d, input bit ok);
        dlWr = 1'b1;
        dlA  = a;
        dlD  = d;
        if (ok) exp_q.push_back({ch, a[18:0], d});
        tick();
        dlWr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        dlIndex  = idx;
        dlActive = 1'b1;
        tick();
    endtask

    task automatic finish_dl(output bit ok);
        dlActive = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (init === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; dlActive = 1'b0; dlWr = 1'b0; dlIndex = 8'd0;
        dlA = 25'd0; dlD = 8'd0; memAck = 1'b0; ack_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        tests++; if ({memReq, init, overflow, rangeErr, dlWait} !== 5'b01000) begin
            fails++; $display("FAIL reset_flags act=%b exp=01000", {memReq, init, overflow, rangeErr, dlWait});
        end
        tests++; if ({loaded, lastSize} !== 24'd0) begin
            fails++; $display("FAIL reset_status loaded=%b lastSize=%0d exp 0/0", loaded, lastSize);
        end
        tests++; if ({memCh, memA, memD} !== 29'd0) begin
            fails++; $display("FAIL reset_mem act=%h exp=0", {memCh, memA, memD});
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'h00; bytes[3] = 8'hFF;
        start_dl(8'd0);
        tests++; if (init !== 1'b0) begin fails++; $display("FAIL basic_init_low act=%b exp=0", init); end
        for (int i = 0; i < 4; i++) strobe(2'd0, 25'(i), bytes[i], 1'b1);
        finish_dl(ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_timeout init=%b exp=1", init); end
        tests++; if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL basic_count act=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [EW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL basic_write act=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        tests++; if (loaded !== 4'b0001 || lastSize !== 20'd4) begin
            fails++; $display("FAIL basic_status loaded=%b lastSize=%0d exp 0001/4", loaded, lastSize);
        end
        tests++; if (rangeErr !== 1'b0 || overflow !== 1'b0) begin
            fails++; $display("FAIL basic_errs rangeErr=%b overflow=%b exp 0/0", rangeErr, overflow);
        end
    endtask

    task automatic test_bad_index();
        bit ok;
        start_dl(8'd6);
        for (int i = 0; i < 3; i++) strobe(2'd2, 25'(i), 8'(8'h40 + i), 1'b0);
        finish_dl(ok);
        tests++; if (!ok) begin fails++; $display("FAIL badidx_timeout init=%b exp=1", init); end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL badidx_writes act=%0d exp=0", obs_q.size()); end
        tests++; if (rangeErr !== 1'b1) begin fails++; $display("FAIL badidx_rangeErr act=%b exp=1", rangeErr); end
        tests++; if (loaded !== 4'b0001 || lastSize !== 20'd0) begin
            fails++; $display("FAIL badidx_status loaded=%b lastSize=%0d exp 0001/0", loaded, lastSize);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow();
        bit ok;
        ack_en = 1'b0;
        start_dl(8'd1);
        for (int i = 0; i < 10; i++) begin
            strobe(2'd1, 25'(i), 8'(8'h10 + i), i < 9);
            if (i == 5) begin
                tests++; if (dlWait !== 1'b0) begin fails++; $display("FAIL ovf_wait_early act=%b exp=0", dlWait); end
            end
            if (i == 7) begin
                tests++; if (dlWait !== 1'b1) begin fails++; $display("FAIL ovf_wait_at6 act=%b exp=1", dlWait); end
            end
        end
        tests++; if (overflow !== 1'b1 || memReq !== 1'b1) begin
            fails++; $display("FAIL ovf_flags overflow=%b memReq=%b exp 1/1", overflow, memReq);
        end
        ack_en = 1'b1;
        finish_dl(ok);
        tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout init=%b exp=1", init); end
        tests++; if (obs_q.size() != 9 || exp_q.size() != 9) begin
            fails++; $display("FAIL ovf_count act=%0d exp=9", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [EW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL ovf_write act=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        tests++; if (loaded !== 4'b0011 || lastSize !== 20'd9 || overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_status loaded=%b lastSize=%0d overflow=%b exp 0011/9/1", loaded, lastSize, overflow);
        end
    endtask

    task automatic test_addr_bounds();
        bit ok;
        start_dl(8'd3);
        strobe(2'd3, 25'h80000, 8'h11, 1'b0);
        strobe(2'd3, 25'h7FFFF, 8'h3C, 1'b1);
        finish_dl(ok);
        tests++; if (!ok) begin fails++; $display("FAIL addr_timeout init=%b exp=1", init); end
        tests++; if (obs_q.size() != 1) begin fails++; $display("FAIL addr_count act=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [EW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL addr_write act=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        tests++; if (rangeErr !== 1'b1 || loaded !== 4'b1011 || lastSize !== 20'd1) begin
            fails++; $display("FAIL addr_status rangeErr=%b loaded=%b lastSize=%0d exp 1/1011/1", rangeErr, loaded, lastSize);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ack_en = 1'b0;
        start_dl(8'd2);
        for (int i = 0; i < 6; i++) strobe(2'd2, 25'(i), 8'(8'h60 + i), 1'b1);
        tests++; if (memReq !== 1'b1) begin fails++; $display("FAIL rmid_req_before act=%b exp=1", memReq); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete(); obs_q.delete();
        tests++; if (memReq !== 1'b0 || init !== 1'b1 || dlWait !== 1'b0 || loaded !== 4'b0000) begin
            fails++; $display("FAIL rmid_after memReq=%b init=%b dlWait=%b loaded=%b exp 0/1/0/0000", memReq, init, dlWait, loaded);
        end
        memAck = 1'b1;
        @(negedge clock);
        memAck = 1'b0;
        tests++; if (init !== 1'b0 || memReq !== 1'b0) begin
            fails++; $display("FAIL rmid_restart init=%b memReq=%b exp 0/0", init, memReq);
        end
        ack_en = 1'b1;
        strobe(2'd2, 25'h00100, 8'h77, 1'b1);
        strobe(2'd2, 25'h00101, 8'h88, 1'b1);
        finish_dl(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rmid_timeout init=%b exp=1", init); end
        tests++; if (obs_q.size() != 2) begin fails++; $display("FAIL rmid_count act=%0d exp=2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [EW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL rmid_write act=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        tests++; if (loaded !== 4'b0100 || lastSize !== 20'd2) begin
            fails++; $display("FAIL rmid_status loaded=%b lastSize=%0d exp 0100/2", loaded, lastSize);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_dl(8'd1);
        for (int i = 0; i < 3; i++) strobe(2'd1, 25'(16 + i), 8'(8'hC0 + i), 1'b1);
        finish_dl(ok);
        tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout init=%b exp=1", init); end
        tests++; if (obs_q.size() != 3) begin fails++; $display("FAIL b2b_count act=%0d exp=3", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [EW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL b2b_write act=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        tests++; if (loaded !== 4'b0110 || lastSize !== 20'd3) begin
            fails++; $display("FAIL b2b_status loaded=%b lastSize=%0d exp 0110/3", loaded, lastSize);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_index();
        test_overflow();
        test_addr_bounds();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ioctl_loader.md
Name: ioctl_loader

Overview:
- Parametrised successor to the single-channel init/iniW/iniA/iniD download path of the platform glue layer.
- Accepts the data_io byte stream (index, address, data, write strobe) and routes each byte by index to one of CHANNELS memory targets.
- Buffers bytes in a FIFO and writes them to slow memory over a req/ack handshake.
- Drives a core-hold signal `init` plus per-channel loaded flags and error flags.

Parameters:
- CHANNELS, 4: number of download targets; channel = dlIndex - BASE_INDEX.
- BASE_INDEX, 0: ioctl index mapped to channel 0.
- IDXW, 8: width of dlIndex.
- AW, 19: memory address width; also the per-channel address window size, 2^AW bytes.
- DW, 8: data width.
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- CHW, clog2(CHANNELS) min 1: channel field width (localparam).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- dlActive  in  1  download in progress (data_io ioctl_download).
- dlIndex  in  IDXW  download index.
- dlWr  in  1  one-cycle byte strobe.
- dlA  in  25  byte address.
- dlD  in  DW  byte data.
- dlWait  out  1  throttle request to the host side.
- memReq  out  1  write request, held until ack.
- memCh  out  CHW  target channel.
- memA  out  AW  write address.
- memD  out  DW  write data.
- memAck  in  1  one-cycle write-accepted pulse.
- init  out  1  1 = idle/complete, 0 = loading (core held).
- loaded  out  CHANNELS  sticky per-channel "image present".
- lastSize  out  AW+1  byte count of the most recent completed download.
- overflow  out  1  sticky: byte dropped because the FIFO was full.
- rangeErr  out  1  sticky: byte dropped for bad index or address >= 2^AW.

Behaviour:
Reset values: memReq 0, memCh/memA/memD 0, init 1, loaded 0, lastSize 0, overflow 0, rangeErr 0, dlWait 0, FIFO empty, state IDLE.

Download start and end:
- Start = rising edge of dlActive, using a registered copy. On start: init<=0, overflow<=0, rangeErr<=0, byte counter<=0. Latch channel = dlIndex - BASE_INDEX (IDXW-bit subtract) as curCh, plus an inRange flag (difference < CHANNELS).
- Push condition: dlWr && dlActive && inRange && dlA[24:AW]==0 && !full.
  - Push writes {curCh, dlA[AW-1:0], dlD} and increments the counter (saturates at 2^AW).
  - dlWr with !inRange or a high address bit set: drop the byte, rangeErr<=1.
  - dlWr while full: drop the byte, overflow<=1. This holds even if a pop occurs the same cycle, so full is evaluated from the registered count.
- Completion = dlActive low && FIFO empty && state IDLE && no pending start. On completion while init==0:
  - init<=1.
  - lastSize<=counter.
  - loaded[curCh]<=1 if counter!=0 and inRange.
- loaded bits clear only on reset. A new download to the same channel keeps its bit set.

dlWait:
- Registered; 1 when FIFO count >= DEPTH-2. This leaves margin for two in-flight strobes.

Write engine FSM:
- IDLE: if FIFO not empty, pop the head into memCh/memA/memD, memReq<=1, go to REQ. Pop and presentation happen in the same cycle, so memReq rises one clock after the entry reaches the head.
- REQ: hold memReq and data stable. On memAck: memReq<=0, go to IDLE. Minimum two cycles per byte, strict FIFO order, at most one outstanding write.
- memAck in IDLE is ignored.
- No timeout: a permanently low memAck stalls the engine. dlWait then asserts and init stays 0.

FIFO:
- Simultaneous push and pop when neither full nor empty: count unchanged.
- Pointers wrap modulo DEPTH.

Reset mid-operation:
- FIFO is flushed and memReq drops in the next cycle regardless of memAck.
- init returns to 1.
- If dlActive is still high after reset releases, the registered edge detector must be initialised to 0 so that a new start is seen and init goes low again.

Decomposition:
- Package ioctl_loader_pkg holds:
  - entry field-width localparams (CHW, AW, DW, entry width).
  - FSM state encoding: IDLE=0, REQ=1.
  - the 25-bit ioctl address width constant shared with the glue layer.
- Sub-module loader_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with push, pop, full, empty and count. It is reused for other glue-layer buffers.

Test Plan:
- Index 0, 4 bytes A5,5A,00,FF at addresses 0..3, memAck 1 cycle after each memReq → four writes in order on ch0, memA 0..3. init goes 0 at start and 1 after the last ack. loaded=0001, lastSize=4.
- BASE_INDEX=0, dlIndex=6, CHANNELS=4, 3 strobes → no memReq, rangeErr=1, init returns 1, loaded unchanged, lastSize=0.
- memAck held low, 10 back-to-back strobes, DEPTH=8 → dlWait=1 at count 6. The byte arriving when full is dropped and overflow=1. After memAck resumes, exactly the 8 buffered entries are written, plus the 1 entry in REQ.
- Address 0x80000 with AW=19 → byte dropped, rangeErr=1. Address 0x7FFFF → written with memA=0x7FFFF.
- Reset asserted while in REQ with 5 entries buffered → next cycle memReq=0, FIFO empty, init=1. Late memAck is ignored, and a new download afterwards behaves normally.
- Downloads to ch2 and then ch1 → loaded=0110, and the second lastSize reflects only ch1's byte count.
